// File: rtl/kovacs_protocol_seq.sv
// Programmable multi-phase DAC source sequencer: routes one of N_SRC streams per step, repeats or runs forever.
// Outputs data_o/indicator_o are registered and trail step_o by one cycle.
module kovacs_protocol_seq #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 14,
  parameter int N_SRC   = 4,
  parameter int N_STEPS = 4,
  parameter int CNT_W   = 32,
  parameter int REP_W   = 16,
  localparam int SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_SRC*IN_W-1:0]      src_i,
  input  logic [N_STEPS*SEL_W-1:0]   sel_i,
  input  logic [N_STEPS*CNT_W-1:0]   dur_i,
  input  logic [STEP_W:0]            n_steps_i,
  input  logic [REP_W-1:0]           n_reps_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  output logic [OUT_W-1:0]           data_o,
  output logic [OUT_W-1:0]           indicator_o,
  output logic [STEP_W-1:0]          step_o,
  output logic                       busy_o,
  output logic                       done_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [OUT_W-1:0] IND_HOT = {1'b0, {(OUT_W-1){1'b1}}};

  state_t                     r_state, w_state_nx;
  logic [STEP_W-1:0]          r_step, w_step_nx;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nx;
  logic [REP_W-1:0]           r_rep, w_rep_nx;
  logic                       r_done, w_done_nx;
  logic [N_STEPS*SEL_W-1:0]   r_sel, w_sel_nx;
  logic [N_STEPS*CNT_W-1:0]   r_dur, w_dur_nx;
  logic [STEP_W-1:0]          r_last, w_last_nx;
  logic [REP_W-1:0]           r_nreps, w_nreps_nx;
  logic [OUT_W-1:0]           r_data, w_data_nx;
  logic [OUT_W-1:0]           r_ind, w_ind_nx;

  logic [CNT_W-1:0]           w_dur_cur;
  logic [REP_W-1:0]           w_rep_inc;
  logic [STEP_W:0]            w_nsteps_m1;
  logic [STEP_W-1:0]          w_last_in;
  logic [SEL_W-1:0]           w_sel_cur;
  logic [31:0]                w_sel_ext;
  logic [SEL_W-1:0]           w_src_idx;

  // n_steps of 0 runs one step; anything above N_STEPS runs all of them
  always_comb begin
    w_nsteps_m1 = n_steps_i - (STEP_W+1)'(1);
    w_last_in   = w_nsteps_m1[STEP_W-1:0];
    if (n_steps_i == '0) begin
      w_last_in = '0;
    end else if (n_steps_i > (STEP_W+1)'(N_STEPS)) begin
      w_last_in = STEP_W'(N_STEPS - 1);
    end
  end

  assign w_dur_cur = r_dur[r_step*CNT_W +: CNT_W];
  assign w_rep_inc = r_rep + REP_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_cnt_nx   = r_cnt;
    w_rep_nx   = r_rep;
    w_done_nx  = 1'b0;
    w_sel_nx   = r_sel;
    w_dur_nx   = r_dur;
    w_last_nx  = r_last;
    w_nreps_nx = r_nreps;
    case (r_state)
      S_IDLE: begin
        w_step_nx = '0;
        w_cnt_nx  = '0;
        if (start_i && !stop_i) begin
          w_state_nx = S_RUN;
          w_rep_nx   = '0;
          w_sel_nx   = sel_i;
          w_dur_nx   = dur_i;
          w_last_nx  = w_last_in;
          w_nreps_nx = n_reps_i;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          w_state_nx = S_IDLE;
          w_step_nx  = '0;
          w_cnt_nx   = '0;
          w_rep_nx   = '0;
        end else if (r_cnt == w_dur_cur) begin
          w_cnt_nx = '0;
          if (r_step == r_last) begin
            w_step_nx = '0;
            w_rep_nx  = w_rep_inc;
            // n_reps of 0 never matches here, so rep_q simply wraps
            if (r_nreps != '0 && w_rep_inc == r_nreps) begin
              w_state_nx = S_IDLE;
              w_done_nx  = 1'b1;
            end
          end else begin
            w_step_nx = r_step + STEP_W'(1);
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Idle always plays source 0; out-of-range selects also fall back to source 0
  always_comb begin
    w_sel_cur = '0;
    if (r_state == S_RUN) begin
      w_sel_cur = r_sel[r_step*SEL_W +: SEL_W];
    end
    w_sel_ext = 32'(w_sel_cur);
    w_src_idx = (w_sel_ext >= 32'(N_SRC)) ? '0 : w_sel_cur;
    w_data_nx = src_i[w_src_idx*IN_W + (IN_W-OUT_W) +: OUT_W];
    w_ind_nx  = (r_state == S_RUN && r_step == '0) ? IND_HOT : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_cnt   <= '0;
      r_rep   <= '0;
      r_done  <= 1'b0;
      r_sel   <= '0;
      r_dur   <= '0;
      r_last  <= '0;
      r_nreps <= '0;
      r_data  <= '0;
      r_ind   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
      r_cnt   <= w_cnt_nx;
      r_rep   <= w_rep_nx;
      r_done  <= w_done_nx;
      r_sel   <= w_sel_nx;
      r_dur   <= w_dur_nx;
      r_last  <= w_last_nx;
      r_nreps <= w_nreps_nx;
      r_data  <= w_data_nx;
      r_ind   <= w_ind_nx;
    end
  end

  assign data_o      = r_data;
  assign indicator_o = r_ind;
  assign step_o      = r_step;
  assign busy_o      = (r_state == S_RUN);
  assign done_o      = r_done;

endmodule

// File: tb/tb_kovacs_protocol_seq.sv
// Directed bench for kovacs_protocol_seq: a 4-source instance plus a 3-source instance for select clamping.
module tb_kovacs_protocol_seq;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   src;
  logic [47:0]   src3;
  logic [7:0]    sel;
  logic [127:0]  dur;
  logic [2:0]    n_steps;
  logic [15:0]   n_reps;
  logic          start, stop;
  logic [13:0]   data, ind, data3, ind3;
  logic [1:0]    step, step3;
  logic          busy, done, busy3, done3;

  int checks = 0;
  int errors = 0;
  int bad;

  always #5 clk = ~clk;

  kovacs_protocol_seq u_dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .sel_i(sel), .dur_i(dur),
    .n_steps_i(n_steps), .n_reps_i(n_reps), .start_i(start), .stop_i(stop),
    .data_o(data), .indicator_o(ind), .step_o(step), .busy_o(busy), .done_o(done)
  );

  kovacs_protocol_seq #(.N_SRC(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src3), .sel_i(sel), .dur_i(dur),
    .n_steps_i(n_steps), .n_reps_i(n_reps), .start_i(start), .stop_i(stop),
    .data_o(data3), .indicator_o(ind3), .step_o(step3), .busy_o(busy3), .done_o(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int es [12];
    es = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
    // source k truncates to k+1 on the 4-source instance
    src     = {16'h0010, 16'h000C, 16'h0008, 16'h0004};
    src3    = {16'h0048, 16'h0044, 16'h0040};
    sel     = 8'b00_00_10_01;
    dur     = {32'd0, 32'd0, 32'd1, 32'd3};
    n_steps = 3'd2;
    n_reps  = 16'd2;
    start   = 1'b0;
    stop    = 1'b0;
    rst_n   = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ind", 32'(ind), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_data_src0", 32'(data), 32'd1);

    // two steps dur {3,1}, sel {1,2}, two repetitions
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("seq_busy", 32'(busy), 32'd1);
      chk("seq_step", 32'(step), 32'(es[i]));
      chk("seq_done", 32'(done), 32'd0);
      chk("seq_data", 32'(data), (i == 0) ? 32'd1 : ((es[i-1] == 0) ? 32'd2 : 32'd3));
      chk("seq_ind", 32'(ind), (i == 0) ? 32'd0 : ((es[i-1] == 0) ? 32'd8191 : 32'd0));
      tick();
    end
    chk("cmp_busy", 32'(busy), 32'd0);
    chk("cmp_done", 32'(done), 32'd1);
    chk("cmp_step", 32'(step), 32'd0);
    chk("cmp_data", 32'(data), 32'd3);

    // back-to-back restart on the done cycle, then reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    chk("b2b_data_idle", 32'(data), 32'd1);
    tick();
    chk("b2b_data", 32'(data), 32'd2);
    chk("b2b_ind", 32'(ind), 32'd8191);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_step", 32'(step), 32'd0);
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_ind", 32'(ind), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // config latching: inputs change after start, sequence unaffected
    n_reps = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    dur = '0;
    sel = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      chk("lat_step", 32'(step), 32'(es[i]));
      chk("lat_data", 32'(data), (i == 0) ? 32'd1 : ((es[i-1] == 0) ? 32'd2 : 32'd3));
      tick();
    end
    chk("lat_done", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("new_step0", 32'(step), 32'd0);
    tick();
    chk("new_step1", 32'(step), 32'd1);
    chk("new_data", 32'(data), 32'd4);
    tick();
    chk("new_done", 32'(done), 32'd1);
    chk("new_data_last", 32'(data), 32'd4);
    tick();
    chk("new_data_idle", 32'(data), 32'd1);

    // n_steps = 0 behaves as one step
    n_steps = 3'd0;
    dur = {32'd0, 32'd0, 32'd0, 32'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ns0_step_a", 32'(step), 32'd0);
    tick();
    chk("ns0_step_b", 32'(step), 32'd0);
    chk("ns0_busy_b", 32'(busy), 32'd1);
    tick();
    chk("ns0_done", 32'(done), 32'd1);
    chk("ns0_busy", 32'(busy), 32'd0);

    // n_steps = 7 clamps to four steps
    n_steps = 3'd7;
    dur = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ns7_step", 32'(step), 32'(i));
      chk("ns7_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("ns7_done", 32'(done), 32'd1);
    tick();

    // abort during a long step, then start+stop together in idle
    n_steps = 3'd1;
    dur = {32'd0, 32'd0, 32'd0, 32'd100};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_step", 32'(step), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_done_late", 32'(done), 32'd0);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", 32'(busy), 32'd0);
    tick();
    chk("ss_busy_late", 32'(busy), 32'd0);

    // truncation and one-cycle source latency
    src[15:0] = 16'hFFFC;
    tick();
    chk("trunc_fffc", 32'(data), 32'h3FFF);
    src[15:0] = 16'h0003;
    tick();
    chk("trunc_0003", 32'(data), 32'h0000);
    src[15:0] = 16'h0004;

    // continuous mode past the rep_q wrap, all selects = 3
    n_reps = 16'd0;
    n_steps = 3'd1;
    dur = '0;
    sel = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 70000; k++) begin
      if (busy !== 1'b1 || step !== 2'd0 || done !== 1'b0 || (k > 0 && ind !== 14'd8191))
        bad++;
      tick();
    end
    chk("cont_bad_cycles", 32'(bad), 32'd0);
    chk("cont_busy", 32'(busy), 32'd1);
    chk("cont_data_src3", 32'(data), 32'd4);
    chk("clamp_sel3_busy", 32'(busy3), 32'd1);
    chk("clamp_sel3_data", 32'(data3), 32'h0010);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_stop_done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
